// File: rtl/add_round_key_stage.sv
// Purpose: iterative AES-128 round controller; owns the round state and applies AddRoundKey each round.
// Latency: out_valid rises 2*NR+2 cycles after the accept edge (22 for NR=10); one block in flight.
// Backpressure: in_ready only in IDLE; DONE holds ct_out stable until out_ready, then returns to IDLE.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    plaintext request handshake, pt_in captured on accept
//   rk_en/rk_addr        round-key read strobe and index (0..NR), one read per FETCH cycle
//   rk_data              round key, valid the cycle after rk_en
//   mix_in/sr_in         round datapath results computed from state_q
//   state_q/round        round state register and current round index
//   out_valid/out_ready  ciphertext handshake, ct_out mirrors state_q
module add_round_key_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] pt_in,
  output logic         rk_en,
  output logic [3:0]   rk_addr,
  input  logic [0:127] rk_data,
  input  logic [0:127] mix_in,
  input  logic [0:127] sr_in,
  output logic [0:127] state_q,
  output logic [3:0]   round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ct_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ADD   = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_t         fsm_q;
  fsm_t         fsm_d;
  logic [0:127] pt_q;
  logic [0:127] ark_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    rk_en     = 1'b0;
    rk_addr   = 4'd0;
    out_valid = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = FETCH;
      end
      FETCH: begin
        // state_q is held here so mix_in/sr_in settle before ADD samples them
        rk_en   = 1'b1;
        rk_addr = round;
        fsm_d   = ADD;
      end
      ADD: begin
        fsm_d = (round == LAST_ROUND) ? DONE : FETCH;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Round 0 whitens the plaintext; the last round skips mixColumns.
  always_comb begin
    ark_src = mix_in;
    if (round == 4'd0) begin
      ark_src = pt_q;
    end else if (round == LAST_ROUND) begin
      ark_src = sr_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_q    <= '0;
      state_q <= '0;
      round   <= 4'd0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            pt_q  <= pt_in;
            round <= 4'd0;
          end
        end
        ADD: begin
          state_q <= ark_src ^ rk_data;
          if (round != LAST_ROUND) round <= round + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign ct_out = state_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
module tb_add_round_key_stage;
  localparam int NR = 10;

  typedef logic [0:127] blk_t;
  typedef struct {
    blk_t pt;
    blk_t key;
    blk_t r0;
    blk_t ct;
    bit   noise;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       rk_en;
  logic [3:0] rk_addr;
  logic [3:0] round;
  logic       out_valid;
  logic       out_ready = 1'b1;
  blk_t       pt_in = '0;
  blk_t       rk_data = '0;
  blk_t       mix_in;
  blk_t       sr_in;
  blk_t       state_q;
  blk_t       ct_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e0 = 0;
  bit ov_prev = 1'b0;
  bit noise = 1'b0;
  blk_t sb_q[$];
  logic [3:0] addr_log[$];
  blk_t rk_mem[0:15];
  vec_t tbl[4];

  add_round_key_stage #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pt_in(pt_in),
    .rk_en(rk_en), .rk_addr(rk_addr), .rk_data(rk_data), .mix_in(mix_in), .sr_in(sr_in),
    .state_q(state_q), .round(round), .out_valid(out_valid), .out_ready(out_ready),
    .ct_out(ct_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-key memory with one cycle of read latency; optionally drives all-ones when not read.
  always @(posedge clk) begin
    if (rk_en) rk_data <= rk_mem[rk_addr];
    else if (noise) rk_data <= '1;
  end

  // ---------------- AES reference datapath ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  function automatic blk_t sub_bytes(input blk_t s);
    blk_t r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic blk_t shift_rows(input blk_t s);
    blk_t r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[8*(w + 4*c) +: 8] = s[8*(w + 4*((c + w) % 4)) +: 8];
    return r;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t r = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c) +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      r[8*(4*c) +: 8]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[8*(4*c+1) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[8*(4*c+2) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[8*(4*c+3) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  assign sr_in  = shift_rows(sub_bytes(state_q));
  assign mix_in = mix_columns(sr_in);

  task automatic load_keys(input blk_t key);
    logic [31:0] w[0:43];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    for (int r = 0; r <= NR; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input blk_t act, input blk_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic monitor_step();
    if (!rst) begin
      if (in_valid && in_ready) e0 = cyc + 1;
      if (rk_en) begin
        addr_log.push_back(rk_addr);
        check("rk_en_outside_fetch", blk_t'(in_ready | out_valid), '0);
      end
      if (out_valid && !ov_prev) check("accept_to_out_valid", blk_t'(cyc - e0), blk_t'(2*NR + 2));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got %h, expected no output", ct_out);
        end else begin
          check("ct_out", ct_out, sb_q.pop_front());
        end
      end
    end
    ov_prev = out_valid;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state_q"}, state_q, '0);
    check({tag, "_round"}, blk_t'(round), '0);
    check({tag, "_out_valid"}, blk_t'(out_valid), '0);
    check({tag, "_rk_en"}, blk_t'(rk_en), '0);
    check({tag, "_rk_addr"}, blk_t'(rk_addr), '0);
    check({tag, "_in_ready"}, blk_t'(in_ready), blk_t'(1));
  endtask

  // Leaves the caller just after the accept edge with in_valid dropped.
  task automatic start(input vec_t v);
    int n = 0;
    @(posedge clk); #1;
    load_keys(v.key);
    noise = v.noise;
    sb_q.push_back(v.ct);
    addr_log.delete();
    pt_in = v.pt;
    in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) note_fail("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    pt_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < budget);
    if (!out_valid) note_fail("out_valid");
  endtask

  task automatic check_addrs();
    check("rk_addr_count", blk_t'(addr_log.size()), blk_t'(NR + 1));
    for (int i = 0; i < addr_log.size() && i <= NR; i++)
      check("rk_addr_seq", blk_t'(addr_log[i]), blk_t'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ov_cnt;
    tbl[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
               r0: 128'h193de3bea0f4e22b9ac68d2ae9f84808, ct: 128'h3925841d02dc09fbdc118597196a0b32, noise: 1'b0};
    tbl[1] = tbl[0];
    tbl[1].noise = 1'b1;
    tbl[2] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
               r0: 128'h00102030405060708090a0b0c0d0e0f0, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, noise: 1'b1};
    tbl[3] = '{pt: '0, key: '0, r0: '0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, noise: 1'b0};

    fork
      forever begin @(negedge clk); monitor_step(); end
    join_none

    // Reset values while rst is held.
    #12;
    check_reset_values("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven vectors.
    for (int v = 0; v < 4; v++) begin
      start(tbl[v]);
      @(posedge clk);
      @(posedge clk); #1;
      check("state_after_round0", state_q, tbl[v].r0);
      wait_out(40);
      @(posedge clk); #1;
      check("idle_after_handshake", blk_t'(in_ready), blk_t'(1));
      check_addrs();
    end

    // Backpressure: DONE holds, requests ignored.
    out_ready = 1'b0;
    start(tbl[0]);
    wait_out(40);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = (k == 1 || k == 2);
      pt_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("bp_ct_stable", ct_out, tbl[0].ct);
      check("bp_in_ready_low", blk_t'(in_ready), '0);
      check("bp_out_valid_held", blk_t'(out_valid), blk_t'(1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_in_ready", blk_t'(in_ready), blk_t'(1));
    check("bp_idle_out_valid", blk_t'(out_valid), '0);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;

    // Back-to-back with in_valid held high.
    @(posedge clk); #1;
    load_keys(tbl[0].key);
    noise = 1'b0;
    sb_q.push_back(tbl[0].ct);
    sb_q.push_back(tbl[2].ct);
    pt_in = tbl[0].pt;
    in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) note_fail("b2b_first_accept");
    @(posedge clk); #1 pt_in = tbl[2].pt;
    wait_out(40);
    load_keys(tbl[2].key);
    @(negedge clk);
    check("b2b_ready_after_handshake", blk_t'(in_ready), blk_t'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_accepted", blk_t'(in_ready), '0);
    wait_out(40);
    @(posedge clk); #1;

    // Reset during FETCH of round 5.
    start(tbl[0]);
    n = 0;
    do begin @(negedge clk); n++; end while (!(rk_en && rk_addr == 4'd5) && n < 40);
    if (!(rk_en && rk_addr == 4'd5)) note_fail("fetch_round5");
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    ov_cnt = 0;
    repeat (30) begin @(negedge clk); if (out_valid) ov_cnt++; end
    check("midrst_no_out_valid", blk_t'(ov_cnt), '0);
    start(tbl[0]);
    @(posedge clk);
    @(posedge clk); #1;
    check("midrst_state_after_round0", state_q, tbl[0].r0);
    wait_out(40);
    @(posedge clk); #1;
    check_addrs();
    check("scoreboard_drained", blk_t'(sb_q.size()), '0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
